// File: rtl/mux4_arbiter_if.sv
// Bundle of request, resource handshake and grant signals for the 4-way round-robin arbiter.
// master is the arbiter side; slave is the requesters plus downstream resource.
interface mux4_arbiter_if;
  logic [3:0] req;
  logic       port_ready;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       busy;
  logic       port_valid;
  logic [3:0] done;
  logic       timeout;

  modport master (
    input  req, port_ready,
    output sel, grant, busy, port_valid, done, timeout
  );

  modport slave (
    output req, port_ready,
    input  sel, grant, busy, port_valid, done, timeout
  );
endinterface

// File: rtl/mux4_arbiter.sv
// Round-robin owner of a shared 4:1-muxed port: grants one requester at a time, runs the
// valid/ready handshake for it, and force-releases a grant held for MAX_HOLD cycles.
module mux4_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic          clk,
  input  logic          resetn,
  mux4_arbiter_if.master bus
);
  localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [1:0]       ptr;
  logic [1:0]       sel;
  logic [3:0]       grant;
  logic [CNT_W-1:0] cnt;

  logic [1:0] winner;
  logic       owner_req;
  logic       port_valid;
  logic       fire;
  logic       hold_exp;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    winner = ptr;
    for (int i = 3; i >= 0; i--) begin
      if (bus.req[ptr + 2'(i)]) winner = ptr + 2'(i);
    end
  end

  assign owner_req  = bus.req[sel];
  assign port_valid = (state == BUSY) && owner_req;
  assign fire       = port_valid && bus.port_ready;
  // Abort and handshake both outrank the hold limit.
  assign hold_exp   = port_valid && !bus.port_ready && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      ptr   <= 2'd0;
      cnt   <= '0;
      sel   <= 2'd0;
      grant <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req) begin
            sel   <= winner;
            grant <= 4'd1 << winner;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (fire || !owner_req || hold_exp) begin
            state <= IDLE;
            grant <= 4'd0;
            ptr   <= sel + 2'd1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sel        = sel;
  assign bus.grant      = grant;
  assign bus.busy       = (state == BUSY);
  assign bus.port_valid = port_valid;
  assign bus.done       = grant & {4{fire}};
  assign bus.timeout    = hold_exp;
endmodule

// File: tb/tb_mux4_arbiter.sv
// Bench for mux4_arbiter: directed scenarios plus sticky random requests, checked each
// cycle against a transaction-level reference model through an expected-output queue.
module tb_mux4_arbiter;
  localparam int MAX_HOLD = 4;

  logic clk;
  logic resetn;
  mux4_arbiter_if bus ();

  mux4_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] grant;
    logic       busy;
    logic       port_valid;
    logic [3:0] done;
    logic       timeout;
  } out_t;

  out_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  // Reference model: who owns the port (-1 = nobody), whose turn is first, and
  // how many cycles the current owner has already held the port.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_sel   = 0;
  int m_held  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic out_t model_out(input logic [3:0] r, input logic pr);
    out_t o;
    bit   owned, valid;
    owned        = (m_owner >= 0);
    valid        = owned && r[m_owner];
    o.sel        = 2'(m_sel);
    o.grant      = owned ? 4'(1 << m_owner) : 4'd0;
    o.busy       = owned;
    o.port_valid = valid;
    o.done       = (valid && pr) ? 4'(1 << m_owner) : 4'd0;
    o.timeout    = valid && !pr && (m_held == MAX_HOLD - 1);
    return o;
  endfunction

  task automatic model_step(input logic rn, input logic [3:0] r, input logic pr);
    out_t o;
    o = model_out(r, pr);
    if (!rn) begin
      m_owner = -1; m_ptr = 0; m_sel = 0; m_held = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        if (m_owner < 0 && r[(m_ptr + k) % 4]) begin
          m_owner = (m_ptr + k) % 4;
          m_sel   = m_owner;
          m_held  = 0;
        end
      end
    end else if (o.done != 0 || !r[m_owner] || o.timeout) begin
      m_ptr   = (m_owner + 1) % 4;
      m_owner = -1;
    end else begin
      m_held++;
    end
  endtask

  logic       cur_rn;
  logic [3:0] cur_req;
  logic       cur_pr;

  // Apply this cycle's inputs and queue the outputs the model expects for it.
  task automatic drive(input logic rn, input logic [3:0] r, input logic pr);
    resetn = rn; bus.req = r; bus.port_ready = pr;
    cur_rn = rn; cur_req = r; cur_pr = pr;
    exp_q.push_back(model_out(r, pr));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(cur_rn, cur_req, cur_pr);
    #1;
  endtask

  task automatic step(input logic rn, input logic [3:0] r, input logic pr);
    drive(rn, r, pr);
    tick();
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      out_t e;
      e = exp_q.pop_front();
      check("sel",        32'(bus.sel),        32'(e.sel));
      check("grant",      32'(bus.grant),      32'(e.grant));
      check("busy",       32'(bus.busy),       32'(e.busy));
      check("port_valid", 32'(bus.port_valid), 32'(e.port_valid));
      check("done",       32'(bus.done),       32'(e.done));
      check("timeout",    32'(bus.timeout),    32'(e.timeout));
    end
  end

  initial begin
    logic [3:0] rq;
    resetn = 1'b0; bus.req = 4'b1111; bus.port_ready = 1'b1;
    cur_rn = 1'b0; cur_req = 4'b1111; cur_pr = 1'b1;
    @(posedge clk); #1;
    m_owner = -1; m_ptr = 0; m_sel = 0; m_held = 0;

    // Reset held with all requests pending, then round-robin rotation.
    repeat (3) step(1'b0, 4'b1111, 1'b1);
    step(1'b1, 4'b1111, 1'b1);
    check("first_grant", 32'(bus.grant), 32'h1);
    check("first_sel",   32'(bus.sel),   32'h0);
    repeat (9) step(1'b1, 4'b1111, 1'b1);

    // Fairness: after owner 1 completes, 3 beats 0.
    step(1'b0, 4'b0000, 1'b0);
    step(1'b1, 4'b1010, 1'b1);
    check("fair_g1", 32'(bus.grant), 32'h2);
    step(1'b1, 4'b1010, 1'b1);
    step(1'b1, 4'b1011, 1'b1);
    check("fair_g3", 32'(bus.grant), 32'h8);
    step(1'b1, 4'b1011, 1'b1);
    step(1'b1, 4'b1011, 1'b1);
    check("fair_g0", 32'(bus.grant), 32'h1);
    step(1'b1, 4'b1011, 1'b1);

    // Hold limit with a stalled resource.
    step(1'b0, 4'b0000, 1'b0);
    step(1'b1, 4'b0100, 1'b0);
    repeat (3) step(1'b1, 4'b0100, 1'b0);
    drive(1'b1, 4'b0100, 1'b0); #1;
    check("to_pulse", 32'(bus.timeout), 32'h1);
    tick();
    check("to_release", 32'(bus.grant), 32'h0);
    step(1'b1, 4'b0101, 1'b0);
    check("to_next_owner", 32'(bus.grant), 32'h1);
    step(1'b1, 4'b0101, 1'b1);

    // Owner abandons its request mid-grant.
    step(1'b0, 4'b0000, 1'b0);
    step(1'b1, 4'b0010, 1'b0);
    step(1'b1, 4'b0010, 1'b0);
    drive(1'b1, 4'b0000, 1'b0); #1;
    check("abort_pv",   32'(bus.port_valid), 32'h0);
    check("abort_done", 32'(bus.done),       32'h0);
    tick();
    check("abort_release", 32'(bus.grant), 32'h0);
    step(1'b1, 4'b0101, 1'b1);
    check("abort_ptr", 32'(bus.grant), 32'h4);
    step(1'b1, 4'b0101, 1'b1);

    // Handshake on the last permitted cycle, then reset during BUSY.
    step(1'b0, 4'b0000, 1'b0);
    step(1'b1, 4'b0001, 1'b0);
    repeat (3) step(1'b1, 4'b0001, 1'b0);
    drive(1'b1, 4'b0001, 1'b1); #1;
    check("late_done",    32'(bus.done),    32'h1);
    check("late_timeout", 32'(bus.timeout), 32'h0);
    tick();
    step(1'b1, 4'b0010, 1'b1);
    step(1'b0, 4'b0010, 1'b1);
    check("rst_busy_grant", 32'(bus.grant), 32'h0);
    check("rst_busy_busy",  32'(bus.busy),  32'h0);
    check("rst_busy_sel",   32'(bus.sel),   32'h0);

    // Random traffic with sticky requests, a mostly-slow resource and rare resets.
    rq = 4'b0000;
    for (int n = 0; n < 500; n++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 99) < 15) rq[b] = ~rq[b];
      step(($urandom_range(0, 49) != 0), rq, ($urandom_range(0, 9) < 4));
    end

    for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
